// File: rtl/stage_execute_md.sv
// Execute stage: single-cycle ALU with registered EX/MEM outputs, iterative
// signed multiply/divide (one step per cycle), registered branch/jump redirect.
module stage_execute_md #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [4:0]       alu_op,
  input  logic [4:0]       shamt,
  input  logic [16:0]      immediate,
  input  logic [26:0]      target,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] pc_plus_4,
  output logic             out_valid,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] b_out,
  output logic             overflow,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 2 * WIDTH;
  localparam logic [4:0] OP_ADDI = 5'b00101, OP_SW  = 5'b00111, OP_LW  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b00010, OP_BLT = 5'b00110, OP_BEX = 5'b10110;
  localparam logic [4:0] OP_J    = 5'b00001, OP_JAL = 5'b00011, OP_JR  = 5'b00100;
  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011, ALU_SLL = 5'b00100, ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110, ALU_DIV = 5'b00111;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] sext17(input logic [16:0] v);
    return {{(WIDTH-17){v[16]}}, v};
  endfunction

  // Registers
  logic             r_busy, r_is_div, r_neg, r_div_zero, r_div_min;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] r_mag_d;     // mul: |A| addend; div: |B| divisor
  logic             r_out_valid, r_overflow, r_redirect_valid;
  logic [WIDTH-1:0] r_o_out, r_b_out, r_redirect_pc;

  // Decode / single-cycle datapath wires
  logic             w_is_mem, w_is_ctl, w_taken, w_start_md, w_alu_ovf, w_ovf;
  logic [4:0]       w_alu_op;
  logic [WIDTH-1:0] w_alu_b, w_sum, w_dif, w_alu_res, w_result, w_target;
  logic [WIDTH-1:0] w_jump_pc, w_mag_a, w_mag_b;
  // Iterative unit wires
  logic [WIDTH:0]   w_psum, w_shift, w_rdiff;
  logic             w_ge;
  logic [DW-1:0]    w_md_next, w_prod;
  logic [WIDTH-1:0] w_quot, w_md_res;
  logic             w_md_ovf;

  assign in_ready       = ~r_busy;
  assign out_valid      = r_out_valid;
  assign o_out          = r_o_out;
  assign b_out          = r_b_out;
  assign overflow       = r_overflow;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

  // Decode the instruction, evaluate the ALU, branch condition and redirect target
  always_comb begin
    w_is_mem  = (opcode == OP_ADDI) || (opcode == OP_SW) || (opcode == OP_LW);
    w_alu_op  = w_is_mem ? 5'b00000 : alu_op;
    if (w_is_mem) begin
      w_alu_b = sext17(immediate);
    end else if (opcode == OP_BEX) begin
      w_alu_b = {WIDTH{1'b0}};
    end else begin
      w_alu_b = operand_b;
    end
    w_sum     = operand_a + w_alu_b;
    w_dif     = operand_a - w_alu_b;
    w_alu_res = {WIDTH{1'b0}};
    w_alu_ovf = 1'b0;
    case (w_alu_op)
      ALU_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (operand_a[WIDTH-1] == w_alu_b[WIDTH-1]) && (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_alu_res = w_dif;
        w_alu_ovf = (operand_a[WIDTH-1] != w_alu_b[WIDTH-1]) && (w_dif[WIDTH-1] != operand_a[WIDTH-1]);
      end
      ALU_AND: w_alu_res = operand_a & w_alu_b;
      ALU_OR:  w_alu_res = operand_a | w_alu_b;
      ALU_SLL: w_alu_res = operand_a << shamt;
      ALU_SRA: w_alu_res = $signed(operand_a) >>> shamt;
      default: w_alu_res = {WIDTH{1'b0}};
    endcase
    w_jump_pc = {pc_plus_4[WIDTH-1:27], target};
    w_is_ctl  = 1'b1;
    case (opcode)
      OP_BNE: begin
        w_taken  = (operand_a != operand_b);
        w_target = pc_plus_4 + sext17(immediate);
      end
      OP_BLT: begin
        w_taken  = ($signed(operand_b) < $signed(operand_a));
        w_target = pc_plus_4 + sext17(immediate);
      end
      OP_BEX: begin
        w_taken  = (operand_a != {WIDTH{1'b0}});
        w_target = w_jump_pc;
      end
      OP_J, OP_JAL: begin
        w_taken  = 1'b1;
        w_target = w_jump_pc;
      end
      OP_JR: begin
        w_taken  = 1'b1;
        w_target = operand_b;
      end
      default: begin
        w_is_ctl = 1'b0;
        w_taken  = 1'b0;
        w_target = {WIDTH{1'b0}};
      end
    endcase
    w_start_md = ~w_is_ctl && ((w_alu_op == ALU_MUL) || (w_alu_op == ALU_DIV));
    if (w_is_ctl) begin
      w_result = (opcode == OP_JAL) ? pc_plus_4 : {WIDTH{1'b0}};
      w_ovf    = 1'b0;
    end else begin
      w_result = w_alu_res;
      w_ovf    = w_alu_ovf;
    end
    w_mag_a = operand_a[WIDTH-1] ? (~operand_a + WIDTH'(1)) : operand_a;
    w_mag_b = w_alu_b[WIDTH-1] ? (~w_alu_b + WIDTH'(1)) : w_alu_b;
  end

  // One shift-add (mul) or restoring (div) step on magnitudes, plus final sign fix-up
  always_comb begin
    w_psum  = {1'b0, r_acc[DW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_d} : {(WIDTH+1){1'b0}});
    w_shift = {r_acc[DW-1:WIDTH], r_acc[WIDTH-1]};
    w_rdiff = w_shift - {1'b0, r_mag_d};
    w_ge    = (w_shift >= {1'b0, r_mag_d});
    if (r_is_div) begin
      w_md_next = {(w_ge ? w_rdiff[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
    end else begin
      w_md_next = {w_psum, r_acc[WIDTH-1:1]};
    end
    w_prod = r_neg ? (~r_acc + DW'(1)) : r_acc;
    w_quot = r_neg ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    if (!r_is_div) begin
      w_md_res = w_prod[WIDTH-1:0];
      w_md_ovf = ~(&w_prod[DW-1:WIDTH-1]) && (|w_prod[DW-1:WIDTH-1]);
    end else if (r_div_zero) begin
      w_md_res = {WIDTH{1'b0}};
      w_md_ovf = 1'b1;
    end else if (r_div_min) begin
      w_md_res = MIN_VAL;
      w_md_ovf = 1'b1;
    end else begin
      w_md_res = w_quot;
      w_md_ovf = 1'b0;
    end
  end

  // Pipeline state: accept, iterate, write results, flush and reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= 1'b0; r_is_div <= 1'b0; r_neg <= 1'b0; r_div_zero <= 1'b0; r_div_min <= 1'b0;
      r_cnt <= {CW{1'b0}}; r_acc <= {DW{1'b0}}; r_mag_d <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0; r_overflow <= 1'b0; r_redirect_valid <= 1'b0;
      r_o_out <= {WIDTH{1'b0}}; r_b_out <= {WIDTH{1'b0}}; r_redirect_pc <= {WIDTH{1'b0}};
    end else if (flush) begin
      r_busy           <= 1'b0;
      r_out_valid      <= 1'b0;
      r_redirect_valid <= 1'b0;
    end else if (r_busy) begin
      r_redirect_valid <= 1'b0;
      if (r_cnt == CW'(WIDTH)) begin
        r_busy      <= 1'b0;
        r_out_valid <= 1'b1;
        r_o_out     <= w_md_res;
        r_overflow  <= w_md_ovf;
      end else begin
        r_out_valid <= 1'b0;
        r_acc       <= w_md_next;
        r_cnt       <= r_cnt + CW'(1);
      end
    end else if (in_valid) begin
      r_b_out <= operand_b;
      if (w_start_md) begin
        r_busy           <= 1'b1;
        r_out_valid      <= 1'b0;
        r_redirect_valid <= 1'b0;
        r_cnt            <= {CW{1'b0}};
        r_is_div         <= (w_alu_op == ALU_DIV);
        r_neg            <= operand_a[WIDTH-1] ^ w_alu_b[WIDTH-1];
        r_div_zero       <= (w_alu_b == {WIDTH{1'b0}});
        r_div_min        <= (operand_a == MIN_VAL) && (w_alu_b == {WIDTH{1'b1}});
        r_acc            <= {{WIDTH{1'b0}}, ((w_alu_op == ALU_DIV) ? w_mag_a : w_mag_b)};
        r_mag_d          <= (w_alu_op == ALU_DIV) ? w_mag_b : w_mag_a;
      end else begin
        r_out_valid      <= 1'b1;
        r_o_out          <= w_result;
        r_overflow       <= w_ovf;
        r_redirect_valid <= w_taken;
        r_redirect_pc    <= w_taken ? w_target : r_redirect_pc;
      end
    end else begin
      r_out_valid      <= 1'b0;
      r_redirect_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stage_execute_md.sv
// Randomized and directed bench for stage_execute_md against a behavioural model.
module tb_stage_execute_md;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [4:0]  opcode = 5'd0, alu_op = 5'd0, shamt = 5'd0;
  logic [16:0] immediate = 17'd0;
  logic [26:0] target = 27'd0;
  logic [31:0] operand_a = 32'd0, operand_b = 32'd0, pc_plus_4 = 32'd0;
  logic        out_valid, overflow, redirect_valid;
  logic [31:0] o_out, b_out, redirect_pc;

  logic        f48 = 1'b0, v48 = 1'b0, rdy48, ov48, ovf48, rv48;
  logic [4:0]  op48 = 5'd0, aop48 = 5'd0;
  logic [26:0] tgt48 = 27'd0;
  logic [47:0] a48 = 48'd0, b48 = 48'd0, pc48 = 48'd0, o48, bo48, rpc48;

  stage_execute_md #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_op(alu_op), .shamt(shamt), .immediate(immediate), .target(target),
    .operand_a(operand_a), .operand_b(operand_b), .pc_plus_4(pc_plus_4),
    .out_valid(out_valid), .o_out(o_out), .b_out(b_out), .overflow(overflow),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  stage_execute_md #(.WIDTH(48)) dut48 (
    .clock(clock), .reset(reset), .flush(f48), .in_valid(v48), .in_ready(rdy48),
    .opcode(op48), .alu_op(aop48), .shamt(5'd0), .immediate(17'd0), .target(tgt48),
    .operand_a(a48), .operand_b(b48), .pc_plus_4(pc48),
    .out_valid(ov48), .o_out(o48), .b_out(bo48), .overflow(ovf48),
    .redirect_valid(rv48), .redirect_pc(rpc48));

  int total = 0, bad = 0;
  logic [31:0] obs_o, obs_rpc;
  logic        obs_ovf, obs_rv;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] o;
    logic        ovf;
    logic        redir;
    logic [31:0] rpc;
    logic        multi;
  } exp_t;

  // Instruction semantics from the architectural rules, using wide signed arithmetic
  function automatic exp_t ref_model(input logic [4:0] op, input logic [4:0] aop, input logic [4:0] sh,
                                     input logic [16:0] imm, input logic [26:0] tgt,
                                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    exp_t e;
    longint sa, sb, simm, bop, r;
    logic [31:0] bv;
    logic [4:0] eff;
    bit mem;
    sa = longint'($signed(a)); sb = longint'($signed(b)); simm = longint'($signed(imm));
    e = '0;
    mem = (op == 5'd5) || (op == 5'd7) || (op == 5'd8);
    bop = mem ? simm : ((op == 5'd22) ? 64'sd0 : sb);
    bv = bop[31:0];
    eff = mem ? 5'd0 : aop;
    case (op)
      5'd2:  begin e.redir = (a != b); r = longint'(pc) + simm; e.rpc = r[31:0]; end
      5'd6:  begin e.redir = (sb < sa); r = longint'(pc) + simm; e.rpc = r[31:0]; end
      5'd22: begin e.redir = (a != 32'd0); e.rpc = {pc[31:27], tgt}; end
      5'd1:  begin e.redir = 1'b1; e.rpc = {pc[31:27], tgt}; end
      5'd3:  begin e.redir = 1'b1; e.rpc = {pc[31:27], tgt}; e.o = pc; end
      5'd4:  begin e.redir = 1'b1; e.rpc = b; end
      default: begin
        case (eff)
          5'd0: begin r = sa + bop; e.o = r[31:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
          5'd1: begin r = sa - bop; e.o = r[31:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
          5'd2: e.o = a & bv;
          5'd3: e.o = a | bv;
          5'd4: e.o = a << sh;
          5'd5: begin r = sa >>> sh; e.o = r[31:0]; end
          5'd6: begin
            e.multi = 1'b1;
            r = sa * bop; e.o = r[31:0];
            e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
          end
          5'd7: begin
            e.multi = 1'b1;
            if (bop == 64'sd0) begin e.o = 32'd0; e.ovf = 1'b1; end
            else if (sa == -64'sd2147483648 && bop == -64'sd1) begin e.o = 32'h8000_0000; e.ovf = 1'b1; end
            else begin r = sa / bop; e.o = r[31:0]; end
          end
          default: e.o = 32'd0;
        endcase
      end
    endcase
    return e;
  endfunction

  // Issue one instruction, wait (bounded) for its result and compare everything
  task automatic run(input logic [4:0] op, input logic [4:0] aop, input logic [4:0] sh,
                     input logic [16:0] imm, input logic [26:0] tgt,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    exp_t e;
    int low;
    bit seen;
    e = ref_model(op, aop, sh, imm, tgt, a, b, pc);
    @(negedge clock);
    opcode = op; alu_op = aop; shamt = sh; immediate = imm; target = tgt;
    operand_a = a; operand_b = b; pc_plus_4 = pc; in_valid = 1'b1;
    check_val("ready_before", in_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    operand_b = $urandom;
    low = 0; seen = 0;
    for (int k = 0; k < 200; k++) begin
      if (out_valid) begin seen = 1; break; end
      if (!in_ready) low++;
      @(negedge clock);
    end
    check_val("result_seen", seen, 1'b1);
    check_val("latency", low, e.multi ? 33 : 0);
    check_val("o_out", o_out, e.o);
    check_val("overflow", overflow, e.ovf);
    check_val("redirect_valid", redirect_valid, e.redir);
    if (e.redir) check_val("redirect_pc", redirect_pc, e.rpc);
    check_val("b_out", b_out, b);
    check_val("ready_after", in_ready, 1'b1);
    obs_o = o_out; obs_ovf = overflow; obs_rpc = redirect_pc; obs_rv = redirect_valid;
    @(negedge clock);
    check_val("valid_drop", out_valid, 1'b0);
    check_val("redirect_drop", redirect_valid, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] ops [12] = '{5'd0, 5'd5, 5'd7, 5'd8, 5'd2, 5'd6, 5'd22, 5'd1, 5'd3, 5'd4, 5'd9, 5'd31};

  initial begin
    exp_t e1, e2;
    int cnt, low;
    logic [31:0] ra, rb;
    bit seen;

    repeat (2) @(negedge clock);
    check_val("rst_out_valid", out_valid, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check_val("rst_o_out", o_out, 32'd0);
    check_val("rst_b_out", b_out, 32'd0);
    check_val("rst_overflow", overflow, 1'b0);
    check_val("rst_redirect", {redirect_valid, redirect_pc}, 33'd0);
    check_val("rst_ready", in_ready, 1'b1);

    // Directed cases from the block's intended behaviour
    run(5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 32'h7FFF_FFFF, 32'd1, 32'd0);
    check_val("add_ovf_o", obs_o, 32'h8000_0000); check_val("add_ovf_f", obs_ovf, 1'b1);
    run(5'd5, 5'd3, 5'd0, 17'h1FFFF, 27'd0, 32'd5, 32'd77, 32'd0);
    check_val("addi_o", obs_o, 32'd4); check_val("addi_f", obs_ovf, 1'b0);
    run(5'd0, 5'd6, 5'd0, 17'd0, 27'd0, 32'hFFFF_FFFD, 32'd7, 32'd0);
    check_val("mul_neg_o", obs_o, 32'hFFFF_FFEB); check_val("mul_neg_f", obs_ovf, 1'b0);
    run(5'd0, 5'd6, 5'd0, 17'd0, 27'd0, 32'h0001_0000, 32'h0001_0000, 32'd0);
    check_val("mul_ovf_o", obs_o, 32'd0); check_val("mul_ovf_f", obs_ovf, 1'b1);
    run(5'd0, 5'd7, 5'd0, 17'd0, 27'd0, 32'hFFFF_FFF9, 32'd2, 32'd0);
    check_val("div_trunc", obs_o, 32'hFFFF_FFFD);
    run(5'd0, 5'd7, 5'd0, 17'd0, 27'd0, 32'd9, 32'd0, 32'd0);
    check_val("div_zero_o", obs_o, 32'd0); check_val("div_zero_f", obs_ovf, 1'b1);
    run(5'd0, 5'd7, 5'd0, 17'd0, 27'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    check_val("div_min_o", obs_o, 32'h8000_0000); check_val("div_min_f", obs_ovf, 1'b1);
    run(5'd2, 5'd0, 5'd0, 17'h1FFFC, 27'd0, 32'd1, 32'd2, 32'h100);
    check_val("bne_rv", obs_rv, 1'b1); check_val("bne_pc", obs_rpc, 32'h0000_00FC);
    run(5'd6, 5'd0, 5'd0, 17'd8, 27'd0, 32'd3, 32'd3, 32'h200);
    check_val("blt_eq_rv", obs_rv, 1'b0);
    run(5'd3, 5'd0, 5'd0, 17'd0, 27'h40, 32'd0, 32'd0, 32'h0800_0010);
    check_val("jal_o", obs_o, 32'h0800_0010);
    run(5'd4, 5'd0, 5'd0, 17'd0, 27'd0, 32'd0, 32'hDEAD_BEE0, 32'h10);

    // Back-to-back single-cycle instructions
    e1 = ref_model(5'd0, 5'd1, 5'd0, 17'd0, 27'd0, 32'd10, 32'd3, 32'd0);
    e2 = ref_model(5'd0, 5'd3, 5'd0, 17'd0, 27'd0, 32'hF0, 32'h0F, 32'd0);
    @(negedge clock);
    opcode = 5'd0; alu_op = 5'd1; operand_a = 32'd10; operand_b = 32'd3; in_valid = 1'b1;
    @(negedge clock);
    check_val("b2b_v1", out_valid, 1'b1); check_val("b2b_o1", o_out, e1.o);
    alu_op = 5'd3; operand_a = 32'hF0; operand_b = 32'h0F;
    @(negedge clock);
    in_valid = 1'b0;
    check_val("b2b_v2", out_valid, 1'b1); check_val("b2b_o2", o_out, e2.o);
    @(negedge clock);
    check_val("b2b_drop", out_valid, 1'b0);

    // Flush in the middle of a divide, with a competing instruction
    opcode = 5'd0; alu_op = 5'd7; operand_a = 32'd100; operand_b = 32'd7; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; alu_op = 5'd0;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_ready", in_ready, 1'b1);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (out_valid) cnt++;
      @(negedge clock);
    end
    check_val("flush_no_valid", cnt, 0);
    run(5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 32'd20, 32'd22, 32'd0);
    check_val("post_flush_add", obs_o, 32'd42);

    // Reset in the middle of a multiply
    opcode = 5'd0; alu_op = 5'd6; operand_a = 32'd3; operand_b = 32'd5; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("midrst_regs", {out_valid, o_out, b_out, overflow, redirect_valid, redirect_pc}, 131'd0);
    check_val("midrst_ready", in_ready, 1'b1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) cnt++;
      @(negedge clock);
    end
    check_val("midrst_no_valid", cnt, 0);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      ra = pick_operand();
      rb = ($urandom_range(0, 4) == 0) ? ra : pick_operand();
      run(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 9)), 5'($urandom_range(0, 31)),
          17'($urandom), 27'($urandom), ra, rb, $urandom);
    end

    // WIDTH = 48 instance: multiply latency and jump upper-bit preservation
    @(negedge clock);
    op48 = 5'd0; aop48 = 5'd6; a48 = 48'd1 << 30; b48 = 48'd4; v48 = 1'b1;
    @(negedge clock);
    v48 = 1'b0;
    low = 0; seen = 0;
    for (int k = 0; k < 200; k++) begin
      if (ov48) begin seen = 1; break; end
      if (!rdy48) low++;
      @(negedge clock);
    end
    check_val("w48_seen", seen, 1'b1);
    check_val("w48_latency", low, 49);
    check_val("w48_mul_o", o48, 64'h0000_0001_0000_0000);
    check_val("w48_mul_f", ovf48, 1'b0);
    @(negedge clock);
    op48 = 5'd1; pc48 = 48'hABCD_9876_5430; tgt48 = 27'h123_4567; v48 = 1'b1;
    @(negedge clock);
    v48 = 1'b0;
    check_val("w48_j_rv", rv48, 1'b1);
    check_val("w48_j_pc", rpc48, {pc48[47:27], tgt48});
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
